// File: rtl/mult_pkg.sv
// Shared types for the sequential add-shift multiplier: FSM state encoding
// and the iteration count of the ADD/SHIFT loop.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int N_ITER = 8;
    localparam logic [2:0] K_LAST = 3'(N_ITER - 1);

endpackage

// File: rtl/adder_8.sv
// 8-bit adder with carry in/out; the multiplier's only arithmetic resource,
// time-shared across all iterations.
module adder_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] sum,
    output logic       c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {8'b0, c_in};

endmodule

// File: rtl/mult_seq_fsm.sv
// Next-state and datapath-enable decode for the multiplier sequencer.
// Purely combinational; the state register lives in mult_seq_ctrl.
module mult_seq_fsm
    import mult_pkg::*;
(
    input  logic       start,
    input  logic [2:0] k,
    input  logic [1:0] state,
    input  logic       b_lsb,
    output logic       ld,
    output logic       add_en,
    output logic       sub_sel,
    output logic       shift_en,
    output logic [1:0] next_state
);

    always_comb begin
        ld         = 1'b0;
        add_en     = 1'b0;
        sub_sel    = 1'b0;
        shift_en   = 1'b0;
        next_state = state;
        case (state_t'(state))
            IDLE, DONE: begin
                ld         = start;
                next_state = start ? ADD : IDLE;
            end
            ADD: begin
                add_en     = b_lsb;
                // The last multiplier bit carries negative weight in two's complement.
                sub_sel    = (k == K_LAST);
                next_state = SHIFT;
            end
            SHIFT: begin
                shift_en   = 1'b1;
                next_state = (k == K_LAST) ? DONE : ADD;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer and register datapath for an 8x8 signed add-shift multiplier.
// Holds A, B, S, X and the iteration count; drives one shared adder_8.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 x_bit,
    output logic [1:0]           state_dbg
);

    // Handshake: start is taken on an edge only in IDLE or DONE (never queued);
    // busy is high for the 16 ADD/SHIFT cycles, done for the single cycle after,
    // and product is valid whenever busy is low following a completed run.

    state_t     state;
    logic [1:0] next_state;
    logic [7:0] a, b, s;
    logic       x;
    logic [2:0] k;

    logic       ld, add_en, sub_sel, shift_en;
    logic [7:0] sop, sum;
    logic       c_out;

    mult_seq_fsm u_fsm (
        .start      (start),
        .k          (k),
        .state      (state),
        .b_lsb      (b[0]),
        .ld         (ld),
        .add_en     (add_en),
        .sub_sel    (sub_sel),
        .shift_en   (shift_en),
        .next_state (next_state)
    );

    assign sop = sub_sel ? ~s : s;

    adder_8 u_adder (
        .a     (a),
        .b     (sop),
        .c_in  (sub_sel),
        .sum   (sum),
        .c_out (c_out)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            k     <= 3'd0;
            a     <= 8'd0;
            b     <= 8'd0;
            s     <= 8'd0;
            x     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_t'(next_state);
            busy  <= (state_t'(next_state) == ADD) || (state_t'(next_state) == SHIFT);
            done  <= (state_t'(next_state) == DONE);
            if (ld) begin
                s <= multiplicand;
                b <= multiplier;
                a <= 8'd0;
                x <= 1'b0;
                k <= 3'd0;
            end else if (add_en) begin
                a <= sum;
                // Ninth (sign) bit of the 9-bit sum {A[7],A} +/- {S[7],S}.
                x <= a[7] ^ sop[7] ^ c_out;
            end else if (shift_en) begin
                a <= {x, a[7:1]};
                b <= {a[0], b[7:1]};
                k <= k + 3'd1;
            end
        end
    end

    assign product   = {a, b};
    assign x_bit     = x;
    assign state_dbg = state;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: a timing/arithmetic reference model
// compared every cycle, plus literal product checks from hand calculation.
module tb_mult_seq_ctrl;
    import mult_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  multiplicand = 8'd0;
    logic [7:0]  multiplier = 8'd0;
    logic        busy, done, x_bit;
    logic [15:0] product;
    logic [1:0]  state_dbg;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    mult_seq_ctrl #(.WIDTH(8)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .x_bit        (x_bit),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A run is 16 busy cycles after the accepting edge, then one done cycle
    // carrying the signed product of the operands present at that edge.
    int          m_cnt = 0;
    bit          m_done = 1'b0;
    bit          m_valid = 1'b1;
    logic [15:0] m_prod = 16'd0;
    logic [15:0] m_pend = 16'd0;

    always @(posedge Clk) begin
        logic signed [7:0] smc, smp;
        int p;
        if (Reset) begin
            m_cnt = 0; m_done = 1'b0; m_valid = 1'b1; m_prod = 16'd0;
        end else if (m_cnt == 0 && start) begin
            smc = multiplicand;
            smp = multiplier;
            p = smc * smp;
            m_pend = p[15:0];
            m_cnt = 2 * N_ITER;
            m_done = 1'b0;
            m_valid = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1'b1;
                m_prod = m_pend;
                m_valid = 1'b1;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        if (chk_on) begin
            chk("cyc_busy", 32'(busy), 32'(m_cnt > 0));
            chk("cyc_done", 32'(done), 32'(m_done));
            if (m_valid) begin
                chk("cyc_product", 32'(product), 32'(m_prod));
                chk("cyc_x_bit", 32'(x_bit), 32'(m_prod[15]));
            end
            if (m_cnt == 0)
                chk("cyc_state", 32'(state_dbg), m_done ? 32'(DONE) : 32'(IDLE));
        end
    end

    // ---------------- driver tasks ----------------
    // Called at the negedge that is cycle 1 after the accepting edge; returns
    // at the negedge where done is observed.
    task automatic wait_done(input string name, input logic [15:0] exp_prod,
                             input int poke, input bit hold);
        int n = 1;
        int bcount = 0;
        while (!done && n < 40) begin
            if (busy) bcount++;
            if (poke > 0 && n == poke) start = 1'b1;
            if (poke > 0 && n == poke + 1 && !hold) start = 1'b0;
            @(negedge Clk);
            n++;
        end
        chk({name, "_done_cycle"}, 32'(n), 32'd17);
        chk({name, "_busy_cycles"}, 32'(bcount), 32'd16);
        chk({name, "_product"}, 32'(product), 32'(exp_prod));
    endtask

    task automatic run(input string name, input logic [7:0] mc, input logic [7:0] mp,
                       input logic [15:0] exp_prod, input int poke, input bit hold);
        multiplicand = mc;
        multiplier = mp;
        start = 1'b1;
        @(negedge Clk);
        if (!hold) start = 1'b0;
        multiplicand = $urandom_range(0, 255);
        multiplier = $urandom_range(0, 255);
        wait_done(name, exp_prod, poke, hold);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        chk_on = 1'b1;
        chk("reset_product", 32'(product), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_x_bit", 32'(x_bit), 32'd0);
        @(negedge Clk);

        run("mul_07x03", 8'h07, 8'h03, 16'h0015, 0, 1'b0);
        chk("mul_07x03_x_bit", 32'(x_bit), 32'd0);
        @(negedge Clk);

        run("mul_ffxff", 8'hFF, 8'hFF, 16'h0001, 0, 1'b0);
        @(negedge Clk);

        run("mul_80x80", 8'h80, 8'h80, 16'h4000, 0, 1'b0);
        chk("mul_80x80_x_bit", 32'(x_bit), 32'd0);
        @(negedge Clk);

        // start pulsed again at cycle 5 while busy must be ignored
        run("mul_7fx80", 8'h7F, 8'h80, 16'hC080, 5, 1'b0);
        @(negedge Clk);
        chk("mul_7fx80_idle_product", 32'(product), 32'hC080);

        run("mul_81x7f", 8'h81, 8'h7F, 16'hC0FF, 0, 1'b0);
        run("mul_0cxf6", 8'h0C, 8'hF6, 16'hFF88, 0, 1'b0);
        run("mul_00x9c", 8'h00, 8'h9C, 16'h0000, 0, 1'b0);
        @(negedge Clk);

        // back-to-back: start held through DONE with new operands
        run("b2b_first", 8'h03, 8'h04, 16'h000C, 0, 1'b1);
        multiplicand = 8'h02;
        multiplier = 8'hFD;
        @(negedge Clk);
        start = 1'b0;
        chk("b2b_no_idle_busy", 32'(busy), 32'd1);
        wait_done("b2b_second", 16'hFFFA, 0, 1'b0);
        @(negedge Clk);

        // reset in cycle 9 of a run abandons it
        multiplicand = 8'h05;
        multiplier = 8'h05;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (8) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("midreset_state", 32'(state_dbg), 32'(IDLE));
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_product", 32'(product), 32'd0);
        chk("midreset_x_bit", 32'(x_bit), 32'd0);
        @(negedge Clk);
        run("mul_05x05", 8'h05, 8'h05, 16'h0019, 0, 1'b0);
        repeat (2) @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
